// File: rtl/rls_step_sequencer.sv
// Step sequencer for a time-multiplexed TAPS-tap RLS update: walks the shared MAC array and
// divider through gain, P and weight phases, then strobes the P and w register writes.
module rls_step_sequencer #(
   parameter  int TAPS        = 4,
   parameter  int DIV_TIMEOUT = 40,
   localparam int IW          = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic          Clk,
   input  logic          Rst_n,
   // valid/ready: a sample transfers on a rising edge where s_valid and s_ready are both high.
   input  logic          s_valid,
   output logic          s_ready,
   output logic          shift_en,
   output logic          mac_start,
   output logic [2:0]    mac_sel,
   output logic [IW-1:0] mac_idx,
   input  logic          mac_done,
   output logic          div_start,
   output logic [IW-1:0] div_idx,
   input  logic          div_done,
   input  logic          div_zero,
   output logic          p_we,
   output logic          w_we,
   output logic          step_done,
   output logic          step_abort,
   output logic          err_flag,
   input  logic          err_clr,
   output logic          busy,
   output logic [15:0]   step_count,
   output logic [3:0]    dbg_state
);

   localparam int CW = $clog2(DIV_TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(DIV_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SHIFT, S_MATVEC, S_DOT, S_DIV, S_VECMAT, S_OUTER, S_PUPD, S_WUPD, S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] div_wait;

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= S_IDLE;
         s_ready    <= 1'b1;
         shift_en   <= 1'b0;
         mac_start  <= 1'b0;
         mac_sel    <= 3'd0;
         mac_idx    <= '0;
         div_start  <= 1'b0;
         div_idx    <= '0;
         div_wait   <= '0;
         p_we       <= 1'b0;
         w_we       <= 1'b0;
         step_done  <= 1'b0;
         step_abort <= 1'b0;
         err_flag   <= 1'b0;
         step_count <= 16'd0;
      end else begin
         shift_en   <= 1'b0;
         mac_start  <= 1'b0;
         div_start  <= 1'b0;
         p_we       <= 1'b0;
         w_we       <= 1'b0;
         step_done  <= 1'b0;
         step_abort <= 1'b0;
         if (err_clr) err_flag <= 1'b0;

         // A done in the same cycle as its start pulse is never honoured (start is still high).
         case (state)
            S_IDLE: begin
               if (s_valid && s_ready) begin
                  state    <= S_SHIFT;
                  s_ready  <= 1'b0;
                  shift_en <= 1'b1;
               end
            end
            S_SHIFT: begin
               state     <= S_MATVEC;
               mac_sel   <= 3'd0;
               mac_idx   <= '0;
               mac_start <= 1'b1;
            end
            S_MATVEC, S_VECMAT, S_OUTER: begin
               if (!mac_start && mac_done) begin
                  if (mac_idx != LAST_IDX) begin
                     mac_idx   <= mac_idx + 1'b1;
                     mac_start <= 1'b1;
                  end else begin
                     case (state)
                        S_MATVEC: begin
                           state     <= S_DOT;
                           mac_sel   <= 3'd1;
                           mac_idx   <= '0;
                           mac_start <= 1'b1;
                        end
                        S_VECMAT: begin
                           state     <= S_OUTER;
                           mac_sel   <= 3'd3;
                           mac_idx   <= '0;
                           mac_start <= 1'b1;
                        end
                        default: begin
                           state <= S_PUPD;
                           p_we  <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_DOT: begin
               if (!mac_start && mac_done) begin
                  state     <= S_DIV;
                  div_idx   <= '0;
                  div_wait  <= '0;
                  div_start <= 1'b1;
               end
            end
            S_DIV: begin
               if (!div_start && div_done) begin
                  if (div_zero) begin
                     state      <= S_DONE;
                     step_done  <= 1'b1;
                     step_abort <= 1'b1;
                     err_flag   <= 1'b1;
                  end else if (div_idx != LAST_IDX) begin
                     div_idx   <= div_idx + 1'b1;
                     div_wait  <= '0;
                     div_start <= 1'b1;
                  end else begin
                     state     <= S_VECMAT;
                     mac_sel   <= 3'd2;
                     mac_idx   <= '0;
                     mac_start <= 1'b1;
                  end
               end else if (div_wait == WAIT_MAX) begin
                  // Divider stalled: give up on the step without touching P or w.
                  state      <= S_DONE;
                  step_done  <= 1'b1;
                  step_abort <= 1'b1;
                  err_flag   <= 1'b1;
               end else begin
                  div_wait <= div_wait + 1'b1;
               end
            end
            S_PUPD: begin
               state <= S_WUPD;
               w_we  <= 1'b1;
            end
            S_WUPD: begin
               state      <= S_DONE;
               step_done  <= 1'b1;
               step_count <= step_count + 16'd1;
            end
            S_DONE: begin
               state   <= S_IDLE;
               s_ready <= 1'b1;
            end
            default: begin
               state   <= S_IDLE;
               s_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rls_step_sequencer.sv
// Directed bench for rls_step_sequencer: delay-configurable MAC/divider responder, op-order
// scoreboard and hand-derived latencies for normal, aborted, reset and back-to-back steps.
module tb_rls_step_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        shift_en;
   logic        mac_start;
   logic [2:0]  mac_sel;
   logic [1:0]  mac_idx;
   logic        mac_done;
   logic        div_start;
   logic [1:0]  div_idx;
   logic        div_done;
   logic        div_zero;
   logic        p_we;
   logic        w_we;
   logic        step_done;
   logic        step_abort;
   logic        err_flag;
   logic        err_clr = 1'b0;
   logic        busy;
   logic [15:0] step_count;
   logic [3:0]  dbg_state;

   rls_step_sequencer #(.TAPS(4), .DIV_TIMEOUT(40)) dut (
      .Clk(clk), .Rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .shift_en(shift_en),
      .mac_start(mac_start), .mac_sel(mac_sel), .mac_idx(mac_idx), .mac_done(mac_done),
      .div_start(div_start), .div_idx(div_idx), .div_done(div_done), .div_zero(div_zero),
      .p_we(p_we), .w_we(w_we), .step_done(step_done), .step_abort(step_abort),
      .err_flag(err_flag), .err_clr(err_clr), .busy(busy), .step_count(step_count),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q[$];

   // Bench configuration, written by the driver only.
   bit rand_dly     = 1'b0;
   bit chk_order    = 1'b1;
   int withhold_idx = -1;
   int zero_idx     = -1;
   int stale_req_n  = 0;

   // Monitor/responder state, written by the monitor only.
   int edge_cnt = 0;
   int accept_cnt = 0, accept_edge = 0;
   int pwe_cnt = 0, pwe_edge = 0, wwe_cnt = 0, wwe_edge = 0;
   int done_cnt = 0, done_edge = 0, div_start_edge = 0;
   int start_cnt = 0, overlap_cnt = 0, vecmat_cnt = 0;
   int done_edges[$];
   bit last_abort = 1'b0, err_at_done = 1'b0;
   bit pend = 1'b0, pend_div = 1'b0;
   int pend_idx = 0, dly = 0, stale_seen_n = 0, now = 0;
   logic [7:0] code;

   initial begin
      forever begin
         @(posedge clk);
         edge_cnt = edge_cnt + 1;
      end
   end

   // Samples at the falling edge; "now" is the rising edge that will see these values.
   initial begin
      mac_done = 1'b0;
      div_done = 1'b0;
      div_zero = 1'b0;
      forever begin
         @(negedge clk);
         now = edge_cnt + 1;
         mac_done = 1'b0;
         div_done = 1'b0;
         div_zero = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (s_valid && s_ready) begin accept_cnt++; accept_edge = now; end
            if (p_we) begin pwe_cnt++; pwe_edge = now; end
            if (w_we) begin wwe_cnt++; wwe_edge = now; end
            if (step_done) begin
               done_cnt++;
               done_edge = now;
               done_edges.push_back(now);
               last_abort = step_abort;
               err_at_done = err_flag;
               pend = 1'b0;
            end
            if (mac_start || div_start) begin
               code = div_start ? {4'h4, 2'b00, div_idx} : {1'b0, mac_sel, 2'b00, mac_idx};
               start_cnt++;
               if ((mac_start && div_start) || pend) overlap_cnt++;
               if (div_start) div_start_edge = now;
               if (mac_start && mac_sel == 3'd2) vecmat_cnt++;
               if (chk_order) begin
                  if (exp_q.size() == 0) check("extra_start", 32'(code), 32'hFF);
                  else check("op_order", 32'(code), 32'(exp_q.pop_front()));
               end
               pend = 1'b1;
               pend_div = div_start;
               pend_idx = div_start ? int'(div_idx) : int'(mac_idx);
               dly = rand_dly ? int'($urandom_range(7, 1)) : 1;
            end else if (pend) begin
               dly--;
               if (dly == 0 && !(pend_div && pend_idx == withhold_idx)) begin
                  pend = 1'b0;
                  if (pend_div) begin
                     div_done = 1'b1;
                     div_zero = (pend_idx == zero_idx);
                  end else begin
                     mac_done = 1'b1;
                  end
               end
            end
            if (stale_seen_n != stale_req_n) begin
               mac_done = 1'b1;
               div_done = 1'b1;
               stale_seen_n = stale_req_n;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic push_full_order();
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 3'd0, 2'b00, 2'(i)});
      exp_q.push_back({1'b0, 3'd1, 4'h0});
      for (int i = 0; i < 4; i++) exp_q.push_back({4'h4, 2'b00, 2'(i)});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 3'd2, 2'b00, 2'(i)});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 3'd3, 2'b00, 2'(i)});
   endtask

   task automatic push_prefix(input int n_div);
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 3'd0, 2'b00, 2'(i)});
      exp_q.push_back({1'b0, 3'd1, 4'h0});
      for (int i = 0; i < n_div; i++) exp_q.push_back({4'h4, 2'b00, 2'(i)});
   endtask

   task automatic send_one();
      int a;
      int t;
      a = accept_cnt;
      t = 0;
      @(posedge clk);
      #1 s_valid = 1'b1;
      while (accept_cnt == a && t < 50) begin @(posedge clk); t++; end
      #1 s_valid = 1'b0;
      check("accept_timeout", 32'(accept_cnt != a), 32'd1);
   endtask

   task automatic wait_done_total(input int target, input int budget);
      int t;
      t = 0;
      while (done_cnt < target && t < budget) begin @(posedge clk); t++; end
      #1;
      check("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   int b_start, b_pwe, b_wwe, b_ovl, b_done, b_acc, t, n;

   task automatic snap();
      b_start = start_cnt; b_pwe = pwe_cnt; b_wwe = wwe_cnt;
      b_ovl = overlap_cnt; b_done = done_cnt; b_acc = accept_cnt;
   endtask

   initial begin
      do_reset();
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_step_count", 32'(step_count), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      check("rst_strobes", 32'({shift_en, mac_start, div_start, p_we, w_we, step_done}), 32'd0);

      // Single step with one-cycle responders.
      snap();
      push_full_order();
      send_one();
      wait_done_total(b_done + 1, 200);
      check("t1_latency", 32'(done_edge - accept_edge), 32'd38);
      check("t1_pwe_edge", 32'(pwe_edge - accept_edge), 32'd36);
      check("t1_wwe_edge", 32'(wwe_edge - accept_edge), 32'd37);
      check("t1_step_count", 32'(step_count), 32'd1);
      check("t1_abort", 32'(last_abort), 32'd0);
      check("t1_starts", 32'(start_cnt - b_start), 32'd17);
      check("t1_order_left", 32'(exp_q.size()), 32'd0);
      check("t1_pwe_once", 32'(pwe_cnt - b_pwe), 32'd1);
      check("t1_wwe_once", 32'(wwe_cnt - b_wwe), 32'd1);
      check("t1_s_ready", 32'(s_ready), 32'd1);

      // Random responder delays.
      rand_dly = 1'b1;
      snap();
      push_full_order();
      send_one();
      wait_done_total(b_done + 1, 600);
      check("t2_order_left", 32'(exp_q.size()), 32'd0);
      check("t2_overlap", 32'(overlap_cnt - b_ovl), 32'd0);
      check("t2_pwe_once", 32'(pwe_cnt - b_pwe), 32'd1);
      check("t2_wwe_once", 32'(wwe_cnt - b_wwe), 32'd1);
      check("t2_step_count", 32'(step_count), 32'd2);
      rand_dly = 1'b0;

      // Divider timeout at idx 2.
      withhold_idx = 2;
      snap();
      push_prefix(3);
      send_one();
      wait_done_total(b_done + 1, 300);
      check("t3_timeout", 32'(done_edge - div_start_edge), 32'd40);
      check("t3_abort", 32'(last_abort), 32'd1);
      check("t3_no_pwe", 32'(pwe_cnt - b_pwe), 32'd0);
      check("t3_no_wwe", 32'(wwe_cnt - b_wwe), 32'd0);
      check("t3_err_flag", 32'(err_flag), 32'd1);
      check("t3_step_count", 32'(step_count), 32'd2);
      check("t3_order_left", 32'(exp_q.size()), 32'd0);
      withhold_idx = -1;

      // Divide-by-zero abort with err_clr held: the abort set wins, the next cycle clears.
      @(posedge clk);
      #1 err_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("t4_clr_before", 32'(err_flag), 32'd0);
      zero_idx = 0;
      snap();
      push_prefix(1);
      send_one();
      wait_done_total(b_done + 1, 200);
      check("t4_abort", 32'(last_abort), 32'd1);
      check("t4_set_wins", 32'(err_at_done), 32'd1);
      check("t4_zero_latency", 32'(done_edge - div_start_edge), 32'd2);
      check("t4_cleared", 32'(err_flag), 32'd0);
      check("t4_step_count", 32'(step_count), 32'd2);
      check("t4_no_pwe", 32'(pwe_cnt - b_pwe), 32'd0);
      err_clr = 1'b0;
      zero_idx = -1;

      // Asynchronous reset in the middle of VECMAT.
      chk_order = 1'b0;
      n = vecmat_cnt;
      send_one();
      t = 0;
      while (vecmat_cnt == n && t < 100) begin @(posedge clk); t++; end
      check("t5_vecmat_seen", 32'(vecmat_cnt != n), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("t5_s_ready", 32'(s_ready), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_mac", 32'({mac_start, mac_sel, mac_idx}), 32'd0);
      check("t5_step_count", 32'(step_count), 32'd0);
      check("t5_err_flag", 32'(err_flag), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      snap();
      stale_req_n++;
      repeat (3) @(posedge clk);
      #1;
      check("t5_stale_busy", 32'(busy), 32'd0);
      check("t5_stale_starts", 32'(start_cnt - b_start), 32'd0);
      chk_order = 1'b1;
      push_full_order();
      send_one();
      wait_done_total(b_done + 1, 200);
      check("t5_latency", 32'(done_edge - accept_edge), 32'd38);
      check("t5_step_count", 32'(step_count), 32'd1);
      check("t5_order_left", 32'(exp_q.size()), 32'd0);

      // Back-to-back steps with s_valid held high.
      do_reset();
      snap();
      for (int i = 0; i < 3; i++) push_full_order();
      @(posedge clk);
      #1 s_valid = 1'b1;
      t = 0;
      while (accept_cnt < b_acc + 3 && t < 300) begin @(posedge clk); t++; end
      #1 s_valid = 1'b0;
      wait_done_total(b_done + 3, 200);
      n = done_edges.size();
      check("t6_space1", 32'(done_edges[n-2] - done_edges[n-3]), 32'd39);
      check("t6_space2", 32'(done_edges[n-1] - done_edges[n-2]), 32'd39);
      check("t6_step_count", 32'(step_count), 32'd3);
      check("t6_order_left", 32'(exp_q.size()), 32'd0);

      // Counter wrap.
      @(posedge clk);
      #1 force dut.step_count = 16'hFFFF;
      @(posedge clk);
      #1 release dut.step_count;
      check("t6_preload", 32'(step_count), 32'hFFFF);
      snap();
      push_full_order();
      send_one();
      wait_done_total(b_done + 1, 200);
      check("t6_wrap", 32'(step_count), 32'd0);
      check("t6_wrap_abort", 32'(last_abort), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
